// File: rtl/multi_channel_data_monitor_if.sv
// Sensor/status bundle for multi_channel_data_monitor.
// master drives samples and control, slave returns alarms.
interface multi_channel_data_monitor_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int PERSIST_W = 4
);
    logic [NUM_CH-1:0]        monitor_enable;
    logic                     data_mode;
    logic [DATA_W-1:0]        threshold_high;
    logic [DATA_W-1:0]        threshold_low;
    logic [PERSIST_W-1:0]     persist_count;
    logic                     sensor_valid;
    logic [NUM_CH*DATA_W-1:0] sensor_data;
    logic [NUM_CH-1:0]        software_acknowledgement;
    logic [NUM_CH-1:0]        alarm_output;
    logic                     alarm_any;
    logic [NUM_CH*DATA_W-1:0] fault_capture;
    logic [15:0]              event_count;

    modport master (
        output monitor_enable, data_mode, threshold_high,
        output threshold_low, persist_count, sensor_valid,
        output sensor_data, software_acknowledgement,
        input  alarm_output, alarm_any, fault_capture, event_count
    );

    modport slave (
        input  monitor_enable, data_mode, threshold_high,
        input  threshold_low, persist_count, sensor_valid,
        input  sensor_data, software_acknowledgement,
        output alarm_output, alarm_any, fault_capture, event_count
    );
endinterface

// File: rtl/multi_channel_data_monitor.sv
// Per-channel threshold alarm FSMs with persistence, latched ack and hysteresis.
// Define PEAK_CAPTURE_EN to keep the peak sample in ALARM instead of the last one.
module multi_channel_data_monitor #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int PERSIST_W = 4
) (
    input  logic clock,
    input  logic reset,
    multi_channel_data_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMING, ALARM, COOLDOWN} state_t;

    state_t                   state [NUM_CH];
    logic [PERSIST_W-1:0]     cnt   [NUM_CH];
    logic [NUM_CH-1:0]        alarm_q;
    logic [NUM_CH*DATA_W-1:0] cap_q;
    logic [15:0]              events_q;

    logic [NUM_CH-1:0]              gt_v, lt_v, take, enter;
    logic [NUM_CH-1:0][PERSIST_W:0] cnt_inc;
    logic [PERSIST_W:0]             p_eff;
    logic [4:0]                     n_enter;
    logic [16:0]                    ev_sum;

    function automatic logic above(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              signed_mode
    );
        if (signed_mode) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign p_eff = (bus.persist_count == '0) ?
                   (PERSIST_W+1)'(1) : {1'b0, bus.persist_count};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] smp, cap;
        assign smp        = bus.sensor_data[i*DATA_W +: DATA_W];
        assign cap        = cap_q[i*DATA_W +: DATA_W];
        assign gt_v[i]    = above(smp, bus.threshold_high, bus.data_mode);
        assign lt_v[i]    = above(bus.threshold_low, smp, bus.data_mode);
        assign cnt_inc[i] = {1'b0, cnt[i]} + (PERSIST_W+1)'(1);
`ifdef PEAK_CAPTURE_EN
        assign take[i]    = above(smp, cap, bus.data_mode);
`else
        assign take[i]    = 1'b1;
        logic unused_cap;
        assign unused_cap = ^cap;
`endif
        // Entry is decided here so the event counter sees the same decision.
        assign enter[i] = bus.sensor_valid & bus.monitor_enable[i] & gt_v[i] &
            (((state[i] == IDLE) & (p_eff == (PERSIST_W+1)'(1))) |
             ((state[i] == ARMING) & (cnt_inc[i] >= p_eff)));
    end

    always_comb begin
        n_enter = '0;
        for (int i = 0; i < NUM_CH; i++)
            n_enter = n_enter + 5'(enter[i]);
        ev_sum = {1'b0, events_q} + {12'd0, n_enter};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            alarm_q  <= '0;
            cap_q    <= '0;
            events_q <= '0;
        end else begin
            events_q <= ev_sum[16] ? 16'hFFFF : ev_sum[15:0];
            for (int i = 0; i < NUM_CH; i++) begin
                unique case (state[i])
                    IDLE: begin
                        cnt[i] <= '0;
                        if (bus.sensor_valid && bus.monitor_enable[i] && gt_v[i])
                            cnt[i] <= PERSIST_W'(1);
                        if (enter[i]) begin
                            state[i]   <= ALARM;
                            alarm_q[i] <= 1'b1;
                            cap_q[i*DATA_W +: DATA_W] <= bus.sensor_data[i*DATA_W +: DATA_W];
                        end else if (bus.sensor_valid && bus.monitor_enable[i] && gt_v[i]) begin
                            state[i] <= ARMING;
                        end
                    end
                    ARMING: begin
                        if (!bus.monitor_enable[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (enter[i]) begin
                            state[i]   <= ALARM;
                            cnt[i]     <= '0;
                            alarm_q[i] <= 1'b1;
                            cap_q[i*DATA_W +: DATA_W] <= bus.sensor_data[i*DATA_W +: DATA_W];
                        end else if (bus.sensor_valid && gt_v[i]) begin
                            cnt[i] <= cnt_inc[i][PERSIST_W-1:0];
                        end else if (bus.sensor_valid) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end
                    end
                    ALARM: begin
                        if (bus.sensor_valid && take[i])
                            cap_q[i*DATA_W +: DATA_W] <= bus.sensor_data[i*DATA_W +: DATA_W];
                        if (bus.software_acknowledgement[i]) begin
                            state[i]   <= COOLDOWN;
                            alarm_q[i] <= 1'b0;
                        end
                    end
                    COOLDOWN: begin
                        if (bus.sensor_valid && lt_v[i])
                            state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign bus.alarm_output  = alarm_q;
    assign bus.alarm_any     = |alarm_q;
    assign bus.fault_capture = cap_q;
    assign bus.event_count   = events_q;
endmodule

// File: tb/tb_multi_channel_data_monitor.sv
// Vector-table bench for multi_channel_data_monitor with a one-deep scoreboard.
// Expected capture in the peak scenario follows PEAK_CAPTURE_EN.
module tb_multi_channel_data_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multi_channel_data_monitor_if #(.DATA_W(8), .NUM_CH(4), .PERSIST_W(4)) bus ();

    multi_channel_data_monitor #(.DATA_W(8), .NUM_CH(4), .PERSIST_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        mode;
        logic [7:0]  th;
        logic [7:0]  tl;
        logic [3:0]  pc;
        logic        valid;
        logic [3:0]  en;
        logic [31:0] data;
        logic [3:0]  ack;
        logic [3:0]  e_alarm;
        logic [31:0] e_cap;
        logic [15:0] e_ev;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  alarm;
        logic [31:0] cap;
        logic [15:0] ev;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic vec_t mk(
        string n, logic r, logic m, logic [7:0] th, logic [7:0] tl,
        logic [3:0] pc, logic v, logic [3:0] en, logic [31:0] d,
        logic [3:0] ack, logic [3:0] ea, logic [31:0] ec, logic [15:0] ee);
        vec_t x;
        x.name = n; x.rst = r; x.mode = m; x.th = th; x.tl = tl;
        x.pc = pc; x.valid = v; x.en = en; x.data = d; x.ack = ack;
        x.e_alarm = ea; x.e_cap = ec; x.e_ev = ee;
        return x;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, req);
    endtask

    logic [31:0] peak_exp;

    initial begin
`ifdef PEAK_CAPTURE_EN
        peak_exp = 32'h000000C0;
`else
        peak_exp = 32'h000000A0;
`endif
        // unsigned entry, strict greater-than
        vecs.push_back(mk("reset",     1, 0, 8'h80, 8'h00, 1, 0, 4'hF, 32'h0, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("u_eq_thr",  0, 0, 8'h80, 8'h00, 1, 1, 4'hF, 32'h80, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("u_above",   0, 0, 8'h80, 8'h00, 1, 1, 4'hF, 32'h81, 0, 4'h1, 32'h81, 1));
        vecs.push_back(mk("u_ack",     0, 0, 8'h80, 8'h00, 1, 0, 4'hF, 32'h0, 4'h1, 4'h0, 32'h81, 1));
        vecs.push_back(mk("u_cool_ex", 0, 0, 8'h80, 8'h10, 1, 1, 4'hF, 32'h0, 0, 4'h0, 32'h81, 1));
        // signed mode, ch0 only
        vecs.push_back(mk("s_neg128",  0, 1, 8'hF0, 8'h00, 1, 1, 4'h1, 32'h80, 0, 4'h0, 32'h81, 1));
        vecs.push_back(mk("s_neg11",   0, 1, 8'hF0, 8'h00, 1, 1, 4'h1, 32'hF5, 0, 4'h1, 32'hF5, 2));
        vecs.push_back(mk("s_ack",     0, 1, 8'hF0, 8'h00, 1, 0, 4'h1, 32'h0, 4'h1, 4'h0, 32'hF5, 2));
        vecs.push_back(mk("s_cool_ex", 0, 1, 8'hF0, 8'h00, 1, 1, 4'h1, 32'hFF, 0, 4'h0, 32'hF5, 2));
        vecs.push_back(mk("s_pos127",  0, 1, 8'hF0, 8'h00, 1, 1, 4'h1, 32'h7F, 0, 4'h1, 32'h7F, 3));
        vecs.push_back(mk("rst_alarm", 1, 1, 8'hF0, 8'h00, 1, 1, 4'h1, 32'hFF, 0, 4'h0, 32'h0, 0));
        // persistence on ch1, P=3, invalid gap holds count
        vecs.push_back(mk("p_s1",      0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_s2",      0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_break",   0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h1000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_s3",      0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_gap1",    0, 0, 8'h80, 8'h00, 3, 0, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_gap2",    0, 0, 8'h80, 8'h00, 3, 0, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_s4",      0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("p_s5",      0, 0, 8'h80, 8'h00, 3, 1, 4'hF, 32'h9000, 0, 4'h2, 32'h9000, 1));
        vecs.push_back(mk("p_zero",    0, 0, 8'h80, 8'h00, 0, 1, 4'hF, 32'h9090, 0, 4'h3, 32'h9090, 2));
        // ack with capture, hysteresis on ch2
        vecs.push_back(mk("h_reset",   1, 0, 8'h80, 8'h40, 1, 0, 4'hF, 32'h0, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("h_entry",   0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h900000, 0, 4'h4, 32'h900000, 1));
        vecs.push_back(mk("h_ackcap",  0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'hA00000, 4'h4, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_50",      0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h500000, 0, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_40",      0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h400000, 0, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_90cool",  0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h900000, 0, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_3F",      0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h3F0000, 0, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_ackidle", 0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h0, 4'h4, 4'h0, 32'hA00000, 1));
        vecs.push_back(mk("h_reentry", 0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h810000, 0, 4'h4, 32'h810000, 2));
        // simultaneous entry, enable drop in ALARM, reset
        vecs.push_back(mk("m_reset",   1, 0, 8'h80, 8'h40, 1, 0, 4'hF, 32'h0, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("m_two",     0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h90000090, 0, 4'h9, 32'h90000090, 2));
        vecs.push_back(mk("m_en_off",  0, 0, 8'h80, 8'h40, 1, 0, 4'h0, 32'h0, 0, 4'h9, 32'h90000090, 2));
        vecs.push_back(mk("m_rst",     1, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h95959595, 0, 4'h0, 32'h0, 0));
        // capture while alarmed: last sample or peak
        vecs.push_back(mk("k_entry",   0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'h90, 0, 4'h1, 32'h90, 1));
        vecs.push_back(mk("k_C0",      0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'hC0, 0, 4'h1, 32'hC0, 1));
        vecs.push_back(mk("k_A0",      0, 0, 8'h80, 8'h40, 1, 1, 4'hF, 32'hA0, 0, 4'h1, peak_exp, 1));
        // disable in ARMING on an invalid cycle drops back to IDLE
        vecs.push_back(mk("a_reset",   1, 0, 8'h80, 8'h40, 2, 0, 4'hF, 32'h0, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("a_arm",     0, 0, 8'h80, 8'h40, 2, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("a_dis",     0, 0, 8'h80, 8'h40, 2, 0, 4'h0, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("a_rearm",   0, 0, 8'h80, 8'h40, 2, 1, 4'hF, 32'h9000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk("a_alarm",   0, 0, 8'h80, 8'h40, 2, 1, 4'hF, 32'h9000, 0, 4'h2, 32'h9000, 1));

        foreach (vecs[k]) begin
            exp_t e;
            reset                        = vecs[k].rst;
            bus.data_mode                = vecs[k].mode;
            bus.threshold_high           = vecs[k].th;
            bus.threshold_low            = vecs[k].tl;
            bus.persist_count            = vecs[k].pc;
            bus.sensor_valid             = vecs[k].valid;
            bus.monitor_enable           = vecs[k].en;
            bus.sensor_data              = vecs[k].data;
            bus.software_acknowledgement = vecs[k].ack;
            e.name  = vecs[k].name;
            e.alarm = vecs[k].e_alarm;
            e.cap   = vecs[k].e_cap;
            e.ev    = vecs[k].e_ev;
            sb.push_back(e);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk({e.name, ".alarm"}, 32'(bus.alarm_output), 32'(e.alarm));
            chk({e.name, ".any"},   32'(bus.alarm_any),    32'(|e.alarm));
            chk({e.name, ".cap"},   bus.fault_capture,     e.cap);
            chk({e.name, ".ev"},    32'(bus.event_count),  32'(e.ev));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
